// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder exposing a bank of NUM_REGS read/write registers.
// Define AXI_LITE_SLAVE_REGS_WSTRB_EN to honour byte strobes; otherwise writes update the full word.
module axi_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr_i,
  input  logic                           s_awvalid_i,
  output logic                           s_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb_i,
  input  logic                           s_wvalid_i,
  output logic                           s_wready_o,
  output logic [1:0]                     s_bresp_o,
  output logic                           s_bvalid_o,
  input  logic                           s_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_araddr_i,
  input  logic                           s_arvalid_i,
  output logic                           s_arready_o,
  output logic [DATA_WIDTH-1:0]          s_rdata_o,
  output logic [1:0]                     s_rresp_o,
  output logic                           s_rvalid_o,
  input  logic                           s_rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned SPAN  = NUM_REGS * BYTES;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t              w_state_q, w_state_d;
  r_state_t              r_state_q, r_state_d;
  logic                  aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic                  bvalid_q, bvalid_d, ar_ready_q, ar_ready_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_hs_c, w_hs_c, ar_hs_c, commit_c, commit_ok_c, rd_ok_c;
  logic [ADDR_WIDTH-1:0] commit_addr_c;
  logic [DATA_WIDTH-1:0] commit_data_c;
  logic [BYTES-1:0]      commit_strb_c, byte_en_c;
  logic [IDX_W-1:0]      commit_idx_c, rd_idx_c;

  assign aw_hs_c = s_awvalid_i & aw_ready_q;
  assign w_hs_c  = s_wvalid_i  & w_ready_q;
  assign ar_hs_c = s_arvalid_i & ar_ready_q;

  assign commit_idx_c = IDX_W'(commit_addr_c >> OFFS);
  assign commit_ok_c  = commit_addr_c < ADDR_WIDTH'(SPAN);
  assign rd_idx_c     = IDX_W'(s_araddr_i >> OFFS);
  assign rd_ok_c      = s_araddr_i < ADDR_WIDTH'(SPAN);

`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
  assign byte_en_c = commit_strb_c;
`else
  // Strobes are folded to all-ones so every accepted write updates the full word.
  assign byte_en_c = commit_strb_c | {BYTES{1'b1}};
`endif

  // Write FSM state and registered channel outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write FSM next state; the commit fires on the edge completing the second of AW/W.
  always_comb begin
    w_state_d     = w_state_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    commit_c      = 1'b0;
    commit_addr_c = s_awaddr_i;
    commit_data_c = s_wdata_i;
    commit_strb_c = s_wstrb_i;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs_c) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs_c) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        commit_addr_c = aw_addr_q;
        if (w_hs_c) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        commit_data_c = w_data_q;
        commit_strb_c = w_strb_q;
        if (aw_hs_c) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready_i) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_c) begin
      bvalid_d = 1'b1;
      bresp_d  = commit_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
    aw_ready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    w_ready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
  end

  // Holding registers for whichever of AW/W arrives first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs_c) aw_addr_q <= s_awaddr_i;
      if (w_hs_c) begin
        w_data_q <= s_wdata_i;
        w_strb_q <= s_wstrb_i;
      end
    end
  end

  // Register bank; out-of-range commits leave it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit_c && commit_ok_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (byte_en_c[b]) regs_q[commit_idx_c][b*8 +: 8] <= commit_data_c[b*8 +: 8];
      end
    end
  end

  // Read FSM state and registered channel outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read FSM next state; the bank is sampled before any same-edge write lands.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_ok_c ? regs_q[rd_idx_c] : '0;
          rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (s_rready_i) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign s_awready_o = aw_ready_q;
  assign s_wready_o  = w_ready_q;
  assign s_bvalid_o  = bvalid_q;
  assign s_bresp_o   = bresp_q;
  assign s_arready_o = ar_ready_q;
  assign s_rvalid_o  = rvalid_q;
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: transaction-level model plus directed scenarios.
module tb_axi_lite_slave_regs;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 8;
  localparam int unsigned SPAN = NR * (DW / 8);

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] regs;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_awaddr_i(awaddr), .s_awvalid_i(awvalid), .s_awready_o(awready),
    .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
    .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
    .s_araddr_i(araddr), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
    .regs_o(regs)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending write (addr + data) and one pending read at most.
  logic [DW-1:0] m_regs [NR];
  bit            have_aw, have_w;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [DW/8-1:0] p_strb;
  bit            e_awready, e_wready, e_arready, e_bvalid, e_rvalid;
  logic [1:0]    e_bresp, e_rresp;
  logic [DW-1:0] e_rdata;

  function automatic logic [DW-1:0] strb_mask(input logic [DW/8-1:0] s);
    logic [DW-1:0] m = '0;
`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
    for (int b = 0; b < DW/8; b++) if (s[b]) m = m | (64'hFF << (8*b));
`else
    m = ~m;
    if (s == 8'h5A) m = ~m;  // never driven; keeps the argument referenced
    m = ~'0;
`endif
    return m;
  endfunction

  always @(posedge clk) begin
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [DW-1:0] mask;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      have_aw = 0; have_w = 0;
      e_awready = 1; e_wready = 1; e_arready = 1;
      e_bvalid = 0; e_rvalid = 0; e_bresp = 2'b00; e_rresp = 2'b00; e_rdata = '0;
    end else begin
      aw_hs = awvalid && e_awready;
      w_hs  = wvalid && e_wready;
      ar_hs = arvalid && e_arready;
      b_hs  = e_bvalid && bready;
      r_hs  = e_rvalid && rready;
      if (ar_hs) begin
        e_rvalid = 1;
        e_rdata  = (araddr < SPAN) ? m_regs[araddr / (DW/8)] : '0;
        e_rresp  = (araddr < SPAN) ? 2'b00 : 2'b10;
      end else if (r_hs) e_rvalid = 0;
      if (aw_hs) begin have_aw = 1; p_addr = awaddr; end
      if (w_hs) begin have_w = 1; p_data = wdata; p_strb = wstrb; end
      if (have_aw && have_w) begin
        if (p_addr < SPAN) begin
          mask = strb_mask(p_strb);
          m_regs[p_addr / (DW/8)] = (m_regs[p_addr / (DW/8)] & ~mask) | (p_data & mask);
        end
        e_bvalid = 1;
        e_bresp  = (p_addr < SPAN) ? 2'b00 : 2'b10;
        have_aw = 0; have_w = 0;
      end else if (b_hs) e_bvalid = 0;
      e_awready = !have_aw && !e_bvalid;
      e_wready  = !have_w && !e_bvalid;
      e_arready = !e_rvalid;
    end
  end

  // Compare every cycle against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("awready", 64'(awready), 64'(e_awready));
      check("wready",  64'(wready),  64'(e_wready));
      check("arready", 64'(arready), 64'(e_arready));
      check("bvalid",  64'(bvalid),  64'(e_bvalid));
      check("rvalid",  64'(rvalid),  64'(e_rvalid));
      if (e_bvalid) check("bresp", 64'(bresp), 64'(e_bresp));
      if (e_rvalid) begin
        check("rdata", rdata, e_rdata);
        check("rresp", 64'(rresp), 64'(e_rresp));
      end
      for (int i = 0; i < NR; i++) check("regs_o", regs[i*DW +: DW], m_regs[i]);
    end
  end

  task automatic send_aw(input logic [AW-1:0] a);
    bit hs = 0;
    int n = 0;
    awaddr = a; awvalid = 1;
    while (!hs && n < 50) begin hs = awready; @(negedge clk); n++; end
    awvalid = 0;
    if (!hs) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bit hs = 0;
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1;
    while (!hs && n < 50) begin hs = wready; @(negedge clk); n++; end
    wvalid = 0;
    if (!hs) check("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    bit hs = 0;
    int n = 0;
    araddr = a; arvalid = 1;
    while (!hs && n < 50) begin hs = arready; @(negedge clk); n++; end
    arvalid = 0;
    if (!hs) check("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_b(input int hold);
    int n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) check("b_timeout", 64'd0, 64'd1);
    repeat (hold) @(negedge clk);
    bready = 1; @(negedge clk); bready = 0;
  endtask

  task automatic take_r();
    int n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) check("r_timeout", 64'd0, 64'd1);
    rready = 1; @(negedge clk); rready = 0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    fork send_aw(a); send_w(d, s); join
    take_b(0);
  endtask

  initial begin
    logic [NR*DW-1:0] snap;
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    @(negedge clk); cmp_en = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    check("reset_regs", 64'(regs != '0), 64'd0);

    // AW and W together: response one cycle after the handshake edge.
    fork send_aw(32'h08); send_w(64'hDEADBEEF_CAFEF00D, 8'hFF); join
    check("same_cycle_bvalid", 64'(bvalid), 64'd1);
    check("same_cycle_bresp", 64'(bresp), 64'd0);
    take_b(0);
    check("reg1", regs[1*DW +: DW], 64'hDEADBEEF_CAFEF00D);

    // W leads AW by three cycles; bvalid held four cycles before bready.
    send_w(64'h0123_4567_89AB_CDEF, 8'hFF);
    check("wready_dropped", 64'(wready), 64'd0);
    repeat (2) @(negedge clk);
    send_aw(32'h10);
    check("w_first_bresp", 64'(bresp), 64'd0);
    repeat (4) @(negedge clk);
    check("bvalid_held", 64'(bvalid), 64'd1);
    take_b(0);
    check("reg2", regs[2*DW +: DW], 64'h0123_4567_89AB_CDEF);

    // AW leads W by two cycles.
    send_aw(32'h28);
    check("awready_dropped", 64'(awready), 64'd0);
    @(negedge clk);
    send_w(64'h1111_2222_3333_4444, 8'hFF);
    take_b(1);
    check("reg5", regs[5*DW +: DW], 64'h1111_2222_3333_4444);

    // Out-of-range read and write.
    send_ar(32'h40);
    check("oor_rdata", rdata, 64'd0);
    check("oor_rresp", 64'(rresp), 64'd2);
    take_r();
    snap = regs;
    fork send_aw(32'h40); send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); join
    check("oor_bresp", 64'(bresp), 64'd2);
    take_b(0);
    check("oor_regs_unchanged", 64'(regs != snap), 64'd0);

    // Same-edge read and write of register 3 returns the old value.
    write(32'h18, 64'h55, 8'hFF);
    fork send_aw(32'h18); send_w(64'h0, 8'hFF); send_ar(32'h18); join
    check("raw_old_value", rdata, 64'h55);
    fork take_b(0); take_r(); join
    send_ar(32'h18);
    check("raw_new_value", rdata, 64'h0);
    take_r();

    // Partial strobe on zeroed register 0; low address bits ignored.
    write(32'h03, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
`ifdef AXI_LITE_SLAVE_REGS_WSTRB_EN
    check("strobe_reg0", regs[0 +: DW], 64'h0000_0000_FFFF_FFFF);
`else
    check("strobe_reg0", regs[0 +: DW], 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    send_ar(32'h0D);
    check("low_bits_read", rdata, 64'hDEADBEEF_CAFEF00D);
    take_r();
    write(32'h3F, 64'hA5A5_0000_5A5A_FFFF, 8'hFF);
    check("reg7_top", regs[7*DW +: DW], 64'hA5A5_0000_5A5A_FFFF);

    // Reset with both responses pending.
    fork send_aw(32'h20); send_w(64'h77, 8'hFF); send_ar(32'h08); join
    check("pre_rst_bvalid", 64'(bvalid), 64'd1);
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    rst = 1;
    @(negedge clk);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_regs", 64'(regs != '0), 64'd0);
    rst = 0;
    @(negedge clk);
    check("post_rst_readies", 64'({awready, wready, arready}), 64'd7);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 The block SHALL be a single-clock AXI4-Lite responder (slave) exposing a register bank.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-003 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-004 Parameter DATA_WIDTH, default 64, AXI data width; legal values are 32 and 64.
REQ-005 Parameter NUM_REGS, default 8, register count; must be a power of 2 and at least 2.
REQ-006 Clock and reset ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
REQ-007 Write-address channel SHALL be:
- s_awaddr_i  in  ADDR_WIDTH  write address
- s_awvalid_i  in  1  write-address valid
- s_awready_o  out  1  write-address ready
REQ-008 Write-data channel SHALL be:
- s_wdata_i  in  DATA_WIDTH  write data
- s_wstrb_i  in  DATA_WIDTH/8  byte strobes
- s_wvalid_i  in  1  write-data valid
- s_wready_o  out  1  write-data ready
REQ-009 Write-response channel SHALL be:
- s_bresp_o  out  2  write response
- s_bvalid_o  out  1  write-response valid
- s_bready_i  in  1  write-response ready
REQ-010 Read-address channel SHALL be:
- s_araddr_i  in  ADDR_WIDTH  read address
- s_arvalid_i  in  1  read-address valid
- s_arready_o  out  1  read-address ready
REQ-011 Read-data channel SHALL be:
- s_rdata_o  out  DATA_WIDTH  read data
- s_rresp_o  out  2  read response
- s_rvalid_o  out  1  read-data valid
- s_rready_i  in  1  read-data ready
REQ-012 Register output SHALL be: regs_o  out  NUM_REGS*DATA_WIDTH  flattened register contents, with register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-013 Address decode SHALL be as follows.
- BYTES = DATA_WIDTH/8.
- Register index = addr / BYTES.
- An address is in range when addr < NUM_REGS*BYTES.
- Low address bits below BYTES are ignored.
REQ-014 The write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
- AW and W are accepted independently, in either order or in the same cycle.
REQ-015 Write-channel ready rules SHALL be:
- s_awready_o = 1 in W_IDLE and W_HAVE_W; 0 otherwise.
- s_wready_o = 1 in W_IDLE and W_HAVE_AW; 0 otherwise.
REQ-016 On the edge where the second of the AW/W handshakes completes, the block SHALL:
- commit the write;
- enter W_RESP, with s_bvalid_o = 1 from the next cycle (latency 1).
REQ-017 An out-of-range write SHALL leave all registers unchanged and return s_bresp_o = 2'b10 (SLVERR); an in-range write returns 2'b00 (OKAY).
REQ-018 In W_RESP, s_bvalid_o and s_bresp_o SHALL hold until s_bready_i = 1; on that handshake the FSM returns to W_IDLE.
- Readies reassert the following cycle.
REQ-019 The read FSM SHALL have states R_IDLE and R_DATA.
- s_arready_o = 1 only in R_IDLE.
- On the AR handshake, s_rdata_o and s_rresp_o are registered and s_rvalid_o = 1 from the next cycle.
REQ-020 An out-of-range read SHALL return s_rdata_o = 0 and s_rresp_o = SLVERR.
REQ-021 s_rvalid_o, s_rdata_o and s_rresp_o SHALL hold stable until s_rready_i = 1; the FSM then returns to R_IDLE.
REQ-022 When a read handshake and a write commit hit the same register on the same edge, the read SHALL return the pre-write value.
REQ-023 Read and write paths SHALL operate concurrently with no mutual stalls; each path has at most one outstanding transaction.
REQ-024 regs_o SHALL reflect a committed write from the cycle after the commit edge.

Reset
REQ-025 While rst_i = 1 at a clk_i edge, the block SHALL:
- clear all registers to 0;
- put both FSMs in IDLE;
- drive s_bvalid_o = s_rvalid_o = 0, s_bresp_o = s_rresp_o = 0 and s_rdata_o = 0.
REQ-026 Reset mid-transaction SHALL discard any captured AW/W/AR and any pending response without emitting it.
REQ-027 In the first cycle after reset deasserts, s_awready_o, s_wready_o and s_arready_o SHALL be 1.

Configuration
REQ-028 Macro AXI_LITE_SLAVE_REGS_WSTRB_EN SHALL control byte-strobe handling.
- Defined: only bytes with s_wstrb_i[b] = 1 are written.
- Undefined: s_wstrb_i is ignored and every accepted write updates the full word.

Verification
REQ-029 AW and W in the same cycle: addr 0x08, data 0xDEADBEEF_CAFEF00D, strb 0xFF -> bvalid one cycle later with OKAY; regs_o register 1 = 0xDEADBEEF_CAFEF00D.
REQ-030 W leads AW by 3 cycles: wready drops after the W handshake; AW to 0x10 -> register 2 written and B OKAY; bvalid held 4 cycles until bready.
REQ-031 Read of 0x40 with NUM_REGS = 8 -> rdata 0, rresp SLVERR; a write to 0x40 -> SLVERR and regs_o unchanged.
REQ-032 Write register 3 = 0x0 with a same-edge read of 0x18, previously holding 0x55 -> rdata 0x55; a subsequent read -> 0x0.
REQ-033 With WSTRB_EN defined, strb 0x0F data 0xFFFF_FFFF_FFFF_FFFF on zeroed register 0 -> 0x0000_0000_FFFF_FFFF; with it undefined -> all ones.
REQ-034 rst_i asserted while bvalid = 1 and rvalid = 1 -> both 0 the next cycle, regs_o all 0, and all readies 1 after release.
